// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared types and constants for the carry-sum adder sequencer
package csa_pkg;

    localparam int CSA_WIDTH   = 64;
    localparam int CSA_ADD_LAT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [CSA_WIDTH-1:0] a;
        logic [CSA_WIDTH-1:0] b;
        logic                 addsum;
    } op_entry_t;

endpackage

// File: rtl/csa_op_sequencer_if.sv
// rtl/csa_op_sequencer_if.sv - operand stream, result stream and adder-side bus
interface csa_op_sequencer_if
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_addsum;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_addsum;
    logic             add_start;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_overflow;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_overflow;

    // master is the environment (producer, consumer and adder); slave is the sequencer
    modport master (
        output in_valid, in_a, in_b, in_addsum, out_ready,
               add_sum, add_cout, add_overflow,
        input  in_ready, add_a, add_b, add_addsum, add_start,
               out_valid, out_sum, out_cout, out_overflow
    );

    modport slave (
        input  in_valid, in_a, in_b, in_addsum, out_ready,
               add_sum, add_cout, add_overflow,
        output in_ready, add_a, add_b, add_addsum, add_start,
               out_valid, out_sum, out_cout, out_overflow
    );

endinterface

// File: rtl/csa_op_fifo.sv
// rtl/csa_op_fifo.sv - synchronous operand FIFO with occupancy count
module csa_op_fifo
    import csa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  op_entry_t              din,
    output op_entry_t              dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    op_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/csa_op_sequencer.sv
// rtl/csa_op_sequencer.sv - buffers operand pairs and runs them one at a time through the adder
module csa_op_sequencer
    import csa_pkg::*;
#(
    parameter int WIDTH   = CSA_WIDTH,
    parameter int DEPTH   = 4,
    parameter int ADD_LAT = CSA_ADD_LAT
) (
    input  logic                   clock,
    input  logic                   reset,
    csa_op_sequencer_if.slave      bus,
    output logic                   add_reset,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int            CW   = $clog2(ADD_LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(ADD_LAT - 1);

    seq_state_t       state;
    logic [CW-1:0]    cnt;
    op_entry_t        din;
    op_entry_t        head;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             addsum_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             valid_q;

    assign din  = '{a: bus.in_a, b: bus.in_b, addsum: bus.in_addsum};
    assign push = bus.in_valid && !full;
    // Next operand leaves the FIFO either from idle or on the edge a held result is taken
    assign pop  = !empty && ((state == IDLE) || ((state == HOLD) && bus.out_ready));

    csa_op_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            addsum_q <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            if (pop) begin
                a_q      <= head.a;
                b_q      <= head.b;
                addsum_q <= head.addsum;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum_q   <= bus.add_sum;
                        cout_q  <= bus.add_cout;
                        ovf_q   <= bus.add_overflow;
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state   <= pop ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = !full;
    assign bus.add_a        = a_q;
    assign bus.add_b        = b_q;
    assign bus.add_addsum   = addsum_q;
    assign bus.add_start    = (state == ISSUE);
    assign bus.out_valid    = valid_q;
    assign bus.out_sum      = sum_q;
    assign bus.out_cout     = cout_q;
    assign bus.out_overflow = ovf_q;
    assign add_reset        = reset;
    assign busy             = (state != IDLE) || !empty;

endmodule

// File: tb/tb_csa_op_sequencer.sv
// tb/tb_csa_op_sequencer.sv - directed and random bench with an adder model and result scoreboard
module tb_csa_op_sequencer;
    import csa_pkg::*;

    localparam int WIDTH   = 64;
    localparam int DEPTH   = 4;
    localparam int ADD_LAT = 2;
    localparam int FCW     = $clog2(DEPTH) + 1;
    localparam logic [65:0] JUNK = {2'b11, 64'hDEAD_BEEF_0BAD_F00D};

    logic           clock = 1'b0;
    logic           reset;
    logic           add_reset;
    logic           busy;
    logic [FCW-1:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int start_count = 0;
    int acc_count = 0;
    int cyc = 0;

    logic [65:0] exp_q [$];
    logic [63:0] got_q [$];
    int          hs_cyc [$];
    logic [65:0] pipe [ADD_LAT];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    csa_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

    csa_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADD_LAT(ADD_LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .add_reset  (add_reset),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    // Result as {overflow, cout, sum}; subtraction carry means no borrow
    function automatic logic [65:0] ref_op(input logic [63:0] a, input logic [63:0] b, input logic sub);
        logic signed [64:0] ws;
        logic [64:0]        wide;
        logic [63:0]        s;
        logic               c;
        ws = sub ? ($signed({a[63], a}) - $signed({b[63], b}))
                 : ($signed({a[63], a}) + $signed({b[63], b}));
        if (sub) begin
            s = a - b;
            c = (a >= b);
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            s    = wide[63:0];
            c    = wide[64];
        end
        return {ws[64] ^ ws[63], c, s};
    endfunction

    always @(posedge clock) begin
        pipe[0] <= bus.add_start ? ref_op(bus.add_a, bus.add_b, bus.add_addsum) : JUNK;
        for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.add_sum      = pipe[ADD_LAT-1][63:0];
    assign bus.add_cout     = pipe[ADD_LAT-1][64];
    assign bus.add_overflow = pipe[ADD_LAT-1][65];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b, input logic s);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_addsum = s;
    endtask

    task automatic drive_rand();
        drive(1'b1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_drain(input int bound, input string tag);
        int n = 0;
        bus.out_ready = 1'b1;
        while ((busy || bus.out_valid || exp_q.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 64'(n < bound), 64'd1);
    endtask

    task automatic wait_valid(input int bound, input string tag);
        int n = 0;
        while (!bus.out_valid && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 64'(bus.out_valid), 64'd1);
    endtask

    task automatic monitor();
        logic [65:0] e;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
            end else begin
                if (bus.add_start) start_count++;
                if (bus.out_valid && !bus.out_ready) begin
                    checks++;
                    assert (bus.add_start === 1'b0) else begin
                        errors++;
                        $error("FAIL start_while_stalled observed=%b expected=0", bus.add_start);
                    end
                end
                if (bus.out_valid && bus.out_ready) begin
                    got_q.push_back(bus.out_sum);
                    hs_cyc.push_back(cyc);
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        errors++;
                        $error("FAIL result_unexpected observed=%h expected=none", bus.out_sum);
                    end
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        checks++;
                        assert ({bus.out_overflow, bus.out_cout, bus.out_sum} === e) else begin
                            errors++;
                            $error("FAIL result observed=%h expected=%h",
                                   {bus.out_overflow, bus.out_cout, bus.out_sum}, e);
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(ref_op(bus.in_a, bus.in_b, bus.in_addsum));
                    acc_count++;
                end
            end
        end
    endtask

    initial begin
        int          s0;
        int          a0;
        int          n;
        int          last_acc;
        logic [63:0] held;

        reset = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, 64'd0, 64'd0, 1'b0);
        fork
            monitor();
        join_none
        tick();
        tick();

        chk("rst_add_reset", 64'(add_reset), 64'd1);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_sum", bus.out_sum, 64'd0);
        chk("rst_add_a", bus.add_a, 64'd0);
        chk("rst_add_b", bus.add_b, 64'd0);
        chk("rst_flags", 64'({bus.out_cout, bus.out_overflow, bus.add_start, bus.add_addsum, busy}), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);

        reset = 1'b0;
        s0 = start_count;
        repeat (5) tick();
        chk("idle_no_start", 64'(start_count - s0), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_add_reset", 64'(add_reset), 64'd0);

        // single add: all-ones plus one
        s0 = start_count;
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
        tick();
        drive(1'b0, 64'd0, 64'd0, 1'b0);
        chk("single_start_n", 64'(bus.add_start), 64'd0);
        tick();
        chk("single_start_n1", 64'(bus.add_start), 64'd1);
        tick();
        chk("single_start_n2", 64'(bus.add_start), 64'd0);
        n = 2;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("single_latency", 64'(n), 64'd4);
        chk("single_sum", bus.out_sum, 64'd0);
        chk("single_cout", 64'(bus.out_cout), 64'd1);
        chk("single_ovf", 64'(bus.out_overflow), 64'd0);
        repeat (3) tick();
        chk("single_hold_valid", 64'(bus.out_valid), 64'd1);
        chk("single_one_start", 64'(start_count - s0), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("single_valid_clr", 64'(bus.out_valid), 64'd0);
        chk("single_cout_kept", 64'(bus.out_cout), 64'd1);

        // back-to-back with the consumer always ready
        got_q.delete();
        hs_cyc.delete();
        bus.out_ready = 1'b1;
        drive(1'b1, 64'h0000_AAAA_BBBB_FFFF, 64'h0000_1000_1234_1001, 1'b0);
        tick();
        drive(1'b1, 64'h1111_2222_3333_4444, 64'h0000_0000_0000_0001, 1'b1);
        tick();
        drive(1'b0, 64'd0, 64'd0, 1'b0);
        wait_drain(50, "b2b_drain");
        chk("b2b_count", 64'(got_q.size()), 64'd2);
        chk("b2b_sum0", got_q[0], 64'h0000_BAAA_CDF0_1000);
        chk("b2b_sum1", got_q[1], 64'h1111_2222_3333_4443);
        chk("b2b_spacing", 64'(hs_cyc[1] - hs_cyc[0]), 64'(ADD_LAT + 2));

        // full FIFO under backpressure
        bus.out_ready = 1'b0;
        s0 = start_count;
        a0 = acc_count;
        for (int i = 0; i < 5; i++) begin
            drive_rand();
            tick();
        end
        drive_rand();
        chk("full_accepts", 64'(acc_count - a0), 64'd5);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("full_count", 64'(fifo_count), 64'(DEPTH));
        wait_valid(20, "full_valid");
        held = bus.out_sum;
        repeat (4) tick();
        chk("full_sum_stable", bus.out_sum, held);
        chk("full_one_start", 64'(start_count - s0), 64'd1);
        chk("full_still_blocked", 64'(acc_count - a0), 64'd5);
        bus.out_ready = 1'b1;
        tick();
        chk("full_no_push_on_pop", 64'(acc_count - a0), 64'd5);
        tick();
        drive(1'b0, 64'd0, 64'd0, 1'b0);
        wait_drain(100, "full_drain");
        chk("full_total", 64'(acc_count - a0), 64'd6);

        // reset while an operation is in WAIT
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            tick();
        end
        drive(1'b0, 64'd0, 64'd0, 1'b0);
        reset = 1'b1;
        tick();
        chk("mid_add_reset", 64'(add_reset), 64'd1);
        reset = 1'b0;
        chk("mid_count", 64'(fifo_count), 64'd0);
        chk("mid_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        s0 = start_count;
        repeat (8) tick();
        chk("mid_valid_later", 64'(bus.out_valid), 64'd0);
        chk("mid_no_start", 64'(start_count - s0), 64'd0);
        chk("mid_queue", 64'(exp_q.size()), 64'd0);

        // simultaneous push and pop at two entries
        a0 = acc_count;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            tick();
        end
        drive(1'b0, 64'd0, 64'd0, 1'b0);
        wait_valid(20, "simul_valid");
        chk("simul_count_before", 64'(fifo_count), 64'd2);
        drive_rand();
        bus.out_ready = 1'b1;
        tick();
        chk("simul_count_after", 64'(fifo_count), 64'd2);
        drive(1'b0, 64'd0, 64'd0, 1'b0);
        wait_drain(100, "simul_drain");
        chk("simul_accepts", 64'(acc_count - a0), 64'd4);

        // random traffic on both handshakes
        last_acc = acc_count;
        drive_rand();
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 2) != 0);
            bus.out_ready = 1'($urandom_range(0, 2) != 0);
            tick();
            if (acc_count != last_acc) begin
                last_acc = acc_count;
                drive_rand();
            end
        end
        drive(1'b0, 64'd0, 64'd0, 1'b0);
        wait_drain(300, "rand_drain");
        chk("final_queue", 64'(exp_q.size()), 64'd0);
        chk("final_busy", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csa_op_sequencer.md
Name: csa_op_sequencer

Overview:
- Upstream/downstream controller for the 64-bit carry-sum adder (csa_64bit).
- Accepts operand pairs and an add/sub select over a valid/ready input handshake, and buffers them in a small FIFO.
- Drives the adder's operand inputs and one-cycle start pulse, waits the adder's fixed latency, then captures sum/cout/overflow into a result register.
- Presents the captured result on a valid/ready output handshake. Only one operation is in flight in the adder at any time.

Parameters:
- WIDTH, 64: operand and sum width.
- DEPTH, 4: operand FIFO entries; power of two, at least 2.
- ADD_LAT, 2: clock edges from the edge that samples add_start=1 to the edge at which add_sum, add_cout and add_overflow are valid; at least 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept; equals !full.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_addsum  in  1  operation select, passed through to the adder unchanged.
- add_a  out  WIDTH  adder operand A; held stable from ISSUE until capture.
- add_b  out  WIDTH  adder operand B; same hold rule.
- add_addsum  out  1  adder operation select; same hold rule.
- add_start  out  1  one-cycle start pulse to the adder.
- add_reset  out  1  adder reset; combinational copy of reset.
- add_sum  in  WIDTH  adder sum.
- add_cout  in  1  adder carry out.
- add_overflow  in  1  adder overflow.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  captured sum.
- out_cout  out  1  captured carry.
- out_overflow  out  1  captured overflow.
- busy  out  1  high when FSM is not IDLE or FIFO is not empty.
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: all outputs 0 except in_ready=1. FIFO is emptied, FSM goes to IDLE, wait counter is 0.
- Reset asserted mid-operation aborts the in-flight operation, discards its result, and discards all buffered operands.
- FIFO push: occurs when in_valid && in_ready. No bypass path. When the FIFO is full, in_ready=0 even if a pop occurs in the same cycle.
- Simultaneous push and pop: both take effect; fifo_count is unchanged.
- Pointer wrap: pointers wrap modulo DEPTH. Full and empty are derived from the count.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE: if the FIFO is not empty, pop the head into the add_a/add_b/add_addsum registers and go to ISSUE.
- ISSUE: add_start=1 for exactly this cycle. Clear the counter. Go to WAIT.
- WAIT: increment the counter each edge. On the edge where counter==ADD_LAT-1:
  - capture add_sum, add_cout and add_overflow into the out_* registers;
  - set out_valid=1;
  - go to HOLD.
- HOLD: out_valid stays high and out_* are stable until out_ready=1 is sampled. On that edge, clear out_valid.
  - If the FIFO is non-empty on that same edge, pop the next entry and go directly to ISSUE.
  - Otherwise go to IDLE.
- Latency: an operand accepted at edge N gives add_start high during cycle N+1..N+2 and out_valid high from edge N+2+ADD_LAT.
- Throughput: with out_ready held at 1, one result every ADD_LAT+2 cycles.
- add_start is never high while out_valid=1 and out_ready=0.
- Result ordering: results come out in acceptance order.
- out_* registers hold their last values after the handshake completes; only out_valid clears.
- Widths: the block does no arithmetic. It passes the adder's outputs through unchanged.

Decomposition:
- Package csa_pkg holds:
  - the state enum seq_state_t (IDLE, ISSUE, WAIT, HOLD);
  - localparam CSA_WIDTH=64;
  - the default ADD_LAT;
  - the FIFO entry struct op_entry_t {a, b, addsum}.
- One sub-module: csa_op_fifo, a synchronous DEPTH-entry FIFO of op_entry_t with push/pop/full/empty/count.

Test Plan:
- The bench uses a behavioural adder model with latency ADD_LAT=2: addsum=0 gives a+b, addsum=1 gives a-b; overflow is signed overflow.
- Reset then idle: all outputs 0, in_ready=1, busy=0, add_start never pulses.
- Single add:
  - stimulus: a=FFFF_FFFF_FFFF_FFFF, b=0000_0000_0000_0001, addsum=0;
  - required: exactly one add_start pulse, then out_valid 4 cycles after acceptance;
  - required values: out_sum=0, out_cout=1, out_overflow=0.
- Back-to-back:
  - stimulus: push (0000_AAAA_BBBB_FFFF + 0000_1000_1234_1001) then (1111_2222_3333_4444 − 1) with out_ready=1;
  - required: sums 0000_BAAA_CDF0_1000 then 1111_2222_3333_4443, in order, with spacing of ADD_LAT+2 cycles.
- Full/backpressure:
  - stimulus: hold out_ready=0 and push 6 ops;
  - required: in_ready drops after the 5th accept (DEPTH=4 plus 1 in flight); fifo_count=4; out_* stable; no second add_start until out_ready=1.
- Reset mid-WAIT: the in-flight result and FIFO contents are discarded; out_valid stays 0; fifo_count=0 on the cycle after reset.
- Simultaneous push and pop at fifo_count=2: fifo_count stays 2 and data order is preserved.
